// File: rtl/pmem_pkg.sv
// Shared constants and types for the line-memory initiator (pmem_arbiter).
// PMEM_ARB_RR_EN selects round-robin arbitration in pmem_arb_grant.
package pmem_pkg;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 16;
    localparam int OFFSET_W = 5;

    localparam logic [ADDR_W-1:0] LINE_ALIGN_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } client_t;

    // Clears the byte offset so the memory always sees a line-aligned address.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & LINE_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pmem_arb_grant.sv
// Grant selection between icache and dcache requests.
// With PMEM_ARB_RR_EN a pointer flop alternates winners on contention; otherwise dcache wins.
module pmem_arb_grant
    import pmem_pkg::*;
(
`ifdef PMEM_ARB_RR_EN
    input  logic    clk,
    input  logic    rst,
    input  logic    grant_en,
`endif
    input  logic    i_req,
    input  logic    d_req,
    output client_t grant
);

`ifdef PMEM_ARB_RR_EN
    client_t rr_ptr_r;

    // Contention goes to the client named by the pointer
    always_comb begin
        grant = ICACHE;
        if (i_req && d_req) begin
            grant = rr_ptr_r;
        end else if (d_req) begin
            grant = DCACHE;
        end else begin
            grant = ICACHE;
        end
    end

    // Pointer names the client that was not served by the latest grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= DCACHE;
        end else if (grant_en) begin
            rr_ptr_r <= (grant == DCACHE) ? ICACHE : DCACHE;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    // Fixed priority: dcache first
    always_comb begin
        grant = ICACHE;
        if (d_req) begin
            grant = DCACHE;
        end else if (i_req) begin
            grant = ICACHE;
        end else begin
            grant = ICACHE;
        end
    end
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates icache and dcache line requests onto one physical-memory port.
// Optional round-robin arbitration is enabled by defining PMEM_ARB_RR_EN.
module pmem_arbiter
    import pmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_t        state_r, state_s;
    client_t           owner_r, owner_s, grant_s;
    logic              pmem_read_r, pmem_read_s;
    logic              pmem_write_r, pmem_write_s;
    logic [ADDR_W-1:0] pmem_address_r, pmem_address_s;
    logic [LINE_W-1:0] pmem_wdata_r, pmem_wdata_s;
    logic              i_resp_r, i_resp_s, d_resp_r, d_resp_s;
    logic [LINE_W-1:0] i_rdata_r, i_rdata_s, d_rdata_r, d_rdata_s;
    logic              d_req_s, any_req_s;

    assign d_req_s   = d_read | d_write;
    assign any_req_s = i_read | d_req_s;

    pmem_arb_grant u_grant (
`ifdef PMEM_ARB_RR_EN
        .clk      (clk),
        .rst      (rst),
        .grant_en ((state_r == IDLE) && any_req_s),
`endif
        .i_req    (i_read),
        .d_req    (d_req_s),
        .grant    (grant_s)
    );

    // Next-state and next-register values; everything holds unless a state acts
    always_comb begin
        state_s        = state_r;
        owner_s        = owner_r;
        pmem_read_s    = pmem_read_r;
        pmem_write_s   = pmem_write_r;
        pmem_address_s = pmem_address_r;
        pmem_wdata_s   = pmem_wdata_r;
        i_resp_s       = 1'b0;
        d_resp_s       = 1'b0;
        i_rdata_s      = i_rdata_r;
        d_rdata_s      = d_rdata_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    owner_s = grant_s;
                    state_s = BUSY;
                    if (grant_s == DCACHE) begin
                        pmem_address_s = line_align(d_address);
                        pmem_wdata_s   = d_wdata;
                        pmem_write_s   = d_write;
                        pmem_read_s    = ~d_write;
                    end else begin
                        pmem_address_s = line_align(i_address);
                        pmem_write_s   = 1'b0;
                        pmem_read_s    = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    pmem_read_s  = 1'b0;
                    pmem_write_s = 1'b0;
                    state_s      = DONE;
                    if (owner_r == DCACHE) begin
                        d_rdata_s = pmem_rdata;
                        d_resp_s  = 1'b1;
                    end else begin
                        i_rdata_s = pmem_rdata;
                        i_resp_s  = 1'b1;
                    end
                end else begin
                    state_s = BUSY;
                end
            end
            // Client still holds its request here; moving on prevents a re-grant
            DONE:    state_s = RECOVER;
            RECOVER: state_s = IDLE;
            default: begin
                state_s      = IDLE;
                pmem_read_s  = 1'b0;
                pmem_write_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            owner_r        <= ICACHE;
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
            pmem_address_r <= {ADDR_W{1'b0}};
            pmem_wdata_r   <= {LINE_W{1'b0}};
            i_resp_r       <= 1'b0;
            d_resp_r       <= 1'b0;
            i_rdata_r      <= {LINE_W{1'b0}};
            d_rdata_r      <= {LINE_W{1'b0}};
        end else begin
            state_r        <= state_s;
            owner_r        <= owner_s;
            pmem_read_r    <= pmem_read_s;
            pmem_write_r   <= pmem_write_s;
            pmem_address_r <= pmem_address_s;
            pmem_wdata_r   <= pmem_wdata_s;
            i_resp_r       <= i_resp_s;
            d_resp_r       <= d_resp_s;
            i_rdata_r      <= i_rdata_s;
            d_rdata_r      <= d_rdata_s;
        end
    end

    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;
    assign pmem_address = pmem_address_r;
    assign pmem_wdata   = pmem_wdata_r;
    assign i_resp       = i_resp_r;
    assign i_rdata      = i_rdata_r;
    assign d_resp       = d_resp_r;
    assign d_rdata      = d_rdata_r;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter with a fixed-latency line memory model.
module tb_pmem_arbiter;
    import pmem_pkg::*;

    localparam int DELAY_MEM = 10;
    localparam int TIMEOUT   = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_address = 16'h0000;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_address = 16'h0000;
    logic [LINE_W-1:0] d_wdata = {LINE_W{1'b0}};
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;

    pmem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] line_pat(input int k);
        return {8{32'hC0DE_0000 | 32'(k)}};
    endfunction

    // Memory model: responds DELAY_MEM edges after a strobe, then one recovery cycle
    logic [LINE_W-1:0] mem [0:2047];
    logic              mem_resp_r = 1'b0;
    logic              mem_rec_r  = 1'b0;
    logic [LINE_W-1:0] mem_rdata_r = {LINE_W{1'b0}};
    int                mem_cnt = 0;
    logic              spur_resp = 1'b0;

    initial for (int k = 0; k < 2048; k++) mem[k] = line_pat(k);

    always @(posedge clk) begin
        mem_resp_r <= 1'b0;
        if ((pmem_read || pmem_write) && !mem_resp_r && !mem_rec_r) begin
            if (mem_cnt == DELAY_MEM - 1) begin
                mem_cnt    <= 0;
                mem_resp_r <= 1'b1;
                if (pmem_write) mem[pmem_address[15:5]] <= pmem_wdata;
                else            mem_rdata_r <= mem[pmem_address[15:5]];
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
        mem_rec_r <= mem_resp_r;
    end

    assign pmem_resp  = mem_resp_r | spur_resp;
    assign pmem_rdata = mem_rdata_r;

    // Activity monitor sampled on the falling edge
    int                cyc = 0, n_iresp = 0, n_dresp = 0, n_rd = 0, n_wr = 0, n_both = 0, n_chg = 0;
    int                rise_q[$];
    int                resp_q[$];
    logic              prev_strb = 1'b0;
    logic [ADDR_W-1:0] prev_addr = 16'h0000;
    logic [ADDR_W-1:0] strb_addr = 16'h0000;

    always @(negedge clk) begin
        cyc++;
        if (i_resp) n_iresp++;
        if (d_resp) n_dresp++;
        if (pmem_read) n_rd++;
        if (pmem_write) n_wr++;
        if (pmem_read && pmem_write) n_both++;
        if ((pmem_read || pmem_write) && !prev_strb) rise_q.push_back(cyc);
        if ((pmem_read || pmem_write) && prev_strb && (pmem_address !== prev_addr)) n_chg++;
        if (pmem_read || pmem_write) strb_addr = pmem_address;
        if (pmem_resp) resp_q.push_back(cyc);
        prev_strb = pmem_read | pmem_write;
        prev_addr = pmem_address;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp(input bit want_d, input string tag);
        int n = 0;
        while (!(want_d ? d_resp : i_resp) && n < TIMEOUT) begin
            tick();
            n++;
        end
        check_val({tag, "_in_time"}, LINE_W'(n < TIMEOUT), LINE_W'(1));
    endtask

    int                s_i, s_d, s_rd, s_wr, s_chg, s_rise, c0, nr, nq, n;
    logic [LINE_W-1:0] a5_line;

    task automatic snap();
        s_i = n_iresp; s_d = n_dresp; s_rd = n_rd; s_wr = n_wr; s_chg = n_chg; s_rise = rise_q.size();
    endtask

    initial begin
        a5_line = {32{8'hA5}};
        repeat (DELAY_MEM + 4) tick();
        check_val("rst_pmem_read",  LINE_W'(pmem_read),    LINE_W'(0));
        check_val("rst_pmem_write", LINE_W'(pmem_write),   LINE_W'(0));
        check_val("rst_i_resp",     LINE_W'(i_resp),       LINE_W'(0));
        check_val("rst_d_resp",     LINE_W'(d_resp),       LINE_W'(0));
        check_val("rst_address",    LINE_W'(pmem_address), LINE_W'(0));
        check_val("rst_wdata",      pmem_wdata,            {LINE_W{1'b0}});
        check_val("rst_i_rdata",    i_rdata,               {LINE_W{1'b0}});
        check_val("rst_d_rdata",    d_rdata,               {LINE_W{1'b0}});
        rst = 1'b0;
        tick();

        // Icache read of line 2
        snap();
        c0 = cyc;
        i_read = 1'b1; i_address = 16'h0040;
        wait_resp(1'b0, "i40");
        check_val("i40_rdata", i_rdata, line_pat(2));
        tick(); i_read = 1'b0;
        repeat (3) tick();
        check_val("i40_latency",  LINE_W'(rise_q[s_rise] - c0), LINE_W'(1));
        check_val("i40_addr",     LINE_W'(strb_addr),           LINE_W'(16'h0040));
        check_val("i40_stable",   LINE_W'(n_chg - s_chg),       LINE_W'(0));
        check_val("i40_read_seen",LINE_W'(n_rd > s_rd),         LINE_W'(1));
        check_val("i40_no_write", LINE_W'(n_wr - s_wr),         LINE_W'(0));
        check_val("i40_one_iresp",LINE_W'(n_iresp - s_i),       LINE_W'(1));
        check_val("i40_no_dresp", LINE_W'(n_dresp - s_d),       LINE_W'(0));

        // Dcache write of A5 pattern (read also high: write wins)
        snap();
        d_write = 1'b1; d_read = 1'b1; d_address = 16'h0120; d_wdata = a5_line;
        wait_resp(1'b1, "dwr");
        tick(); d_write = 1'b0; d_read = 1'b0;
        repeat (3) tick();
        check_val("dwr_write_seen", LINE_W'(n_wr > s_wr),   LINE_W'(1));
        check_val("dwr_no_read",    LINE_W'(n_rd - s_rd),   LINE_W'(0));
        check_val("dwr_addr",       LINE_W'(strb_addr),     LINE_W'(16'h0120));
        check_val("dwr_one_dresp",  LINE_W'(n_dresp - s_d), LINE_W'(1));
        check_val("dwr_no_iresp",   LINE_W'(n_iresp - s_i), LINE_W'(0));

        // Dcache read back
        snap();
        d_read = 1'b1; d_address = 16'h0120;
        wait_resp(1'b1, "drd");
        check_val("drd_rdata", d_rdata, a5_line);
        tick(); d_read = 1'b0;
        repeat (3) tick();
        check_val("drd_one_dresp", LINE_W'(n_dresp - s_d), LINE_W'(1));

        // Unaligned dcache read
        d_read = 1'b1; d_address = 16'h013F;
        wait_resp(1'b1, "dun");
        check_val("dun_rdata", d_rdata, a5_line);
        tick(); d_read = 1'b0;
        repeat (3) tick();
        check_val("dun_addr", LINE_W'(strb_addr), LINE_W'(16'h0120));

        // Simultaneous requests, twice: D then I each time
        for (int rep = 0; rep < 2; rep++) begin
            nr = resp_q.size(); nq = rise_q.size();
            i_read = 1'b1; i_address = 16'h0200;
            d_read = 1'b1; d_address = 16'h0300;
            n = 0;
            while (!(i_resp || d_resp) && n < TIMEOUT) begin tick(); n++; end
            check_val("sim_first_in_time", LINE_W'(n < TIMEOUT), LINE_W'(1));
            check_val("sim_first_is_d",    LINE_W'(d_resp),      LINE_W'(1));
            check_val("sim_first_no_i",    LINE_W'(i_resp),      LINE_W'(0));
            check_val("sim_d_rdata",       d_rdata,              line_pat(24));
            tick(); d_read = 1'b0;
            wait_resp(1'b0, "sim_i");
            check_val("sim_i_rdata",   i_rdata, line_pat(16));
            check_val("sim_gap",       LINE_W'(rise_q[nq+1] - resp_q[nr]), LINE_W'(4));
            tick(); i_read = 1'b0;
            repeat (3) tick();
        end
        check_val("no_dual_strobe", LINE_W'(n_both), LINE_W'(0));

        // Spurious pmem_resp while idle
        repeat (2) tick();
        snap();
        spur_resp = 1'b1;
        tick();
        spur_resp = 1'b0;
        repeat (3) tick();
        check_val("spur_no_iresp", LINE_W'(n_iresp - s_i),         LINE_W'(0));
        check_val("spur_no_dresp", LINE_W'(n_dresp - s_d),         LINE_W'(0));
        check_val("spur_no_strb",  LINE_W'(rise_q.size() - s_rise), LINE_W'(0));
        check_val("spur_state",    LINE_W'(dut.state_r),           LINE_W'(IDLE));
        check_val("spur_i_hold",   i_rdata,                        line_pat(16));
        i_read = 1'b1; i_address = 16'h0060;
        wait_resp(1'b0, "spur_after");
        check_val("spur_after_rdata", i_rdata, line_pat(3));
        tick(); i_read = 1'b0;
        repeat (3) tick();

        // Reset while BUSY
        i_read = 1'b1; i_address = 16'h0080;
        n = 0;
        while (!pmem_read && n < TIMEOUT) begin tick(); n++; end
        check_val("rb_strobe_in_time", LINE_W'(n < TIMEOUT), LINE_W'(1));
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_val("rb_pmem_read",  LINE_W'(pmem_read),   LINE_W'(0));
        check_val("rb_pmem_write", LINE_W'(pmem_write),  LINE_W'(0));
        check_val("rb_i_resp",     LINE_W'(i_resp),      LINE_W'(0));
        check_val("rb_d_resp",     LINE_W'(d_resp),      LINE_W'(0));
        check_val("rb_state",      LINE_W'(dut.state_r), LINE_W'(IDLE));
        check_val("rb_i_rdata",    i_rdata,              {LINE_W{1'b0}});
        i_read = 1'b0;
        repeat (DELAY_MEM + 4) tick();
        rst = 1'b0;
        tick();
        i_read = 1'b1; i_address = 16'h0080;
        wait_resp(1'b0, "rb_after");
        check_val("rb_after_rdata", i_rdata, line_pat(4));
        tick(); i_read = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
